// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and word geometry for the IMEM boot loader
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, FINISH} state_t;
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: shifts bytes MSB-first into a 32-bit word and flags the 4th byte
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);
  logic [WORD_W-9:0] sh_q, sh_d;
  logic [1:0]        cnt_q, cnt_d;
  // keep the three earlier bytes; the fourth joins the word combinationally
  always_comb begin
    sh_d  = clr ? '0 : en ? {sh_q[WORD_W-17:0], din} : sh_q;
    cnt_d = clr ? '0 : en ? cnt_q + 2'd1 : cnt_q;
  end
  // shift register and byte counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  assign word       = {sh_q, din};
  assign word_valid = en & (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into IMEM words and holds the CPU until done (IMEM_LOADER_CHECKSUM_EN adds a sum trailer check)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;
  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic                rdy_q, rdy_d, we_q, we_d, hold_q, hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d, asm_word;
  logic                asm_valid, clr, hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   sum_q, sum_d;
`endif
  assign hs = rx_valid & rdy_q;
  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (hs),
    .din        (rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );
  // next-state and next-output logic; every output is the image of a flop
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    clr     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE:
        if (start) begin
          if (length != '0 && length <= MAX_LEN) begin
            state_d = COLLECT;
            len_d   = length;
            cnt_d   = '0;
            rdy_d   = 1'b1;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            clr     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else err_d = 1'b1;
        end
      COLLECT:
        if (asm_valid) begin
          state_d = WRITE;
          rdy_d   = 1'b0;
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = asm_word;
        end
      WRITE: begin
        cnt_d = cnt_q + LEN_W'(1);
        rdy_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_q;
        state_d = (cnt_d == len_q) ? CHECK : COLLECT;
`else
        state_d = (cnt_d == len_q) ? FINISH : COLLECT;
        rdy_d   = cnt_d != len_q;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:
        if (asm_valid) begin
          rdy_d   = 1'b0;
          state_d = (asm_word == sum_q) ? FINISH : IDLE;
          err_d   = asm_word != sum_q;
          busy_d  = asm_word == sum_q;
        end
`endif
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        hold_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (checksum scenario only when IMEM_LOADER_CHECKSUM_EN is defined)
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  length = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_hold, busy, done, err;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  int          total = 0;
  int          bad = 0;
  int          nwr = 0;
  logic [7:0]  last_addr = '0;

  imem_loader dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .length     (length),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // write log used to detect missing or extra IMEM writes
  always @(negedge clk)
    if (imem_we === 1'b1) begin
      nwr++;
      last_addr = imem_waddr;
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [8:0] len);
    start = 1'b1;
    length = len;
    @(negedge clk);
    start = 1'b0;
    length = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL handshake timeout: rx_ready=%b required 1 within 50 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [7:0] addr, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    total++;
    if ({imem_we, rx_ready, imem_waddr, imem_wdata} !== {1'b1, 1'b0, addr, w}) begin
      bad++;
      $display("FAIL write: we=%b rdy=%b addr=%h data=%h required we=1 rdy=0 addr=%h data=%h",
               imem_we, rx_ready, imem_waddr, imem_wdata, addr, w);
    end
    @(negedge clk);
    total++;
    if ({imem_we, imem_waddr, imem_wdata} !== {1'b0, addr, w}) begin
      bad++;
      $display("FAIL write_hold: we=%b addr=%h data=%h required we=0 addr=%h data=%h",
               imem_we, imem_waddr, imem_wdata, addr, w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL idle timeout: busy=%b required 0 within 20 cycles", busy);
    end
  endtask

  task automatic check_flags(input string name, input logic [4:0] exp);
    total++;
    if ({done, err, cpu_hold, busy, rx_ready} !== exp) begin
      bad++;
      $display("FAIL %s: done/err/hold/busy/rdy=%b required %b", name, {done, err, cpu_hold, busy, rx_ready}, exp);
    end
  endtask

  task automatic check_writes(input string name, input int exp);
    total++;
    if (nwr !== exp) begin
      bad++;
      $display("FAIL %s: write count=%0d required %0d", name, nwr, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err} !== {2'b00, 8'h00, 32'h0, 4'b1000}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b required 0 0 00 00000000 1 0 0 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err);
    end
  endtask

  task automatic load_three(input bit gap, input string name);
    int n0 = nwr;
    do_start(9'd3);
    check_flags({name, "_start"}, 5'b00111);
    send_word(32'h20080005, 8'h00, gap);
    send_word(32'h20090007, 8'h01, gap);
    send_word(32'h01095020, 8'h02, gap);
    wait_idle();
    check_flags({name, "_done"}, 5'b10000);
    repeat (3) @(negedge clk);
    check_writes({name, "_count"}, n0 + 3);
  endtask

  task automatic test_basic();
    load_three(1'b0, "basic");
  endtask

  task automatic test_gaps();
    load_three(1'b1, "gaps");
  endtask

  task automatic test_reject();
    int n0;
    apply_reset();
    n0 = nwr;
    do_start(9'd0);
    check_flags("reject_len0", 5'b01100);
    apply_reset();
    do_start(9'd257);
    check_flags("reject_len257", 5'b01100);
    repeat (3) @(negedge clk);
    check_writes("reject_count", n0);
  endtask

  task automatic test_reset_mid();
    int n0;
    apply_reset();
    do_start(9'd2);
    send_word(32'h11223344, 8'h00, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err} !== {2'b00, 8'h00, 32'h0, 4'b1000}) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b required 0 0 00 00000000 1 0 0 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n0 = nwr;
    do_start(9'd1);
    send_word(32'hDEADBEEF, 8'h00, 1'b0);
    wait_idle();
    check_flags("reload_done", 5'b10000);
    check_writes("reload_count", n0 + 1);
  endtask

  task automatic test_full();
    int n0 = nwr;
    do_start(9'd256);
    check_flags("full_start", 5'b00111);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        start = 1'b1;
        length = 9'd1;
        @(negedge clk);
        start = 1'b0;
        length = '0;
      end
      send_word(32'hC0DE0000 | 32'(i), 8'(i), 1'b0);
    end
    wait_idle();
    check_flags("full_done", 5'b10000);
    repeat (5) @(negedge clk);
    check_writes("full_count", n0 + 256);
    total++;
    if (last_addr !== 8'hFF) begin
      bad++;
      $display("FAIL full_last_addr: addr=%h required ff", last_addr);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic load_sum(input logic [31:0] trailer);
    do_start(9'd2);
    send_word(32'h00000001, 8'h00, 1'b0);
    send_word(32'h00000002, 8'h01, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(trailer[i*8 +: 8], 1'b0);
    wait_idle();
  endtask

  task automatic test_checksum();
    load_sum(32'h00000003);
    check_flags("sum_match", 5'b10000);
    load_sum(32'h00000004);
    check_flags("sum_mismatch", 5'b01100);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_reject();
    test_reset_mid();
    test_full();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the counterpart of the PC-driven read-only fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into 32-bit instruction words.
- Writes each word into the IMEM write port at consecutive word addresses, starting at 0. IMEM is word-addressed; PC steps by 1.
- Holds the CPU (PC reset) until the programmed image is complete.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity is 2^ADDR_W words.
- LEN_W, ADDR_W+1, width of the length input, so the full capacity is expressible.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); one clock domain only.
- start  in  1  single-cycle request to begin a load.
- length  in  LEN_W  number of words to load; sampled only when start is accepted.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  high keeps the PC in reset.
- busy  out  1  load in progress.
- done  out  1  sticky; image complete.
- err  out  1  sticky; request rejected or check failed.

Behaviour:
- Reset values: state IDLE, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0. Internal word and byte counters are 0.
- All outputs are registered.
- States: IDLE, COLLECT, WRITE, CHECK (only with the optional feature), FINISH.
- IDLE, accepted start: start=1 with 1 <= length <= 2^ADDR_W.
  - Latch length; clear counters, done and err.
  - Set busy=1 and cpu_hold=1; go to COLLECT.
- IDLE, rejected start: start=1 with length=0 or length > 2^ADDR_W sets err=1 and stays in IDLE; no write occurs.
- COLLECT:
  - rx_ready=1.
  - Each cycle with rx_valid & rx_ready shifts one byte in; the first byte of a word lands in [31:24], the last in [7:0].
  - The byte counter wraps 3->0; on the 4th handshake go to WRITE.
  - Idle cycles (rx_valid=0) are tolerated indefinitely.
- WRITE:
  - rx_ready=0, imem_we=1 for exactly one cycle, imem_waddr=word_cnt, imem_wdata=assembled word.
  - word_cnt increments.
  - If this was the last word, go to CHECK or FINISH; otherwise return to COLLECT.
- Latency: imem_we is high in the cycle after the 4th-byte handshake. Maximum throughput is 1 word per 5 cycles.
- Held values: imem_waddr and imem_wdata hold their last written values while imem_we=0.
- FINISH: one cycle; then done=1, busy=0, cpu_hold=0, and go to IDLE.
- done and err remain set until the next accepted start.
- No wrap: length=2^ADDR_W ends with a write at the all-ones address; the address never wraps to 0.
- start while busy=1 is ignored, with no effect on length or the counters.
- rx_valid while in IDLE/WRITE/FINISH: no handshake, because rx_ready=0. The byte is not consumed.
- Reset mid-load: all outputs return to reset values immediately (asynchronously). Words already written stay in IMEM with no rollback. A partially assembled word is discarded.
- Re-load after done: an accepted start reasserts cpu_hold=1 in the next cycle.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK and receive 4 more bytes, MSB-first, via the same handshake.
  - Compare them against the running 32-bit sum (mod 2^32) of all written words.
  - Match: FINISH.
  - Mismatch: err=1, done=0, busy=0, cpu_hold stays 1; return to IDLE.
- Undefined: no CHECK state and no sum register; the last WRITE goes directly to FINISH.

Decomposition:
- Package imem_loader_pkg holds:
  - state encoding constants (IDLE, COLLECT, WRITE, CHECK, FINISH);
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- Sub-module byte_assembler: the 8-to-32 shift register plus the 2-bit byte counter. It outputs word and word_valid. The checksum path reuses it.

Test Plan:
1. Reset, then start with length=3 and stream 20 08 00 05 20 09 00 07 01 09 50 20 back-to-back.
   - Expected writes: addr0=20080005, addr1=20090007, addr2=01095020.
   - Each imem_we is 1 cycle, in the cycle after the 4th byte of its word.
   - Then done=1, cpu_hold=0, busy=0.
2. Same stream with rx_valid deasserted for 1-3 random cycles between bytes.
   - Expect identical writes; no byte duplicated or dropped.
   - rx_ready=0 during WRITE.
3. Rejected lengths:
   - start with length=0 gives err=1, no imem_we, cpu_hold=1, busy=0.
   - start with length=257 (ADDR_W=8) gives the same response.
4. Start with length=2, send 6 bytes, pull reset low for 1 cycle.
   - All outputs return to reset values.
   - A new start with length=1 and bytes DE AD BE EF writes addr0=DEADBEEF.
5. Start with length=256 and pulse start again mid-load.
   - The second start is ignored.
   - The last write is at addr FF, with no write to addr 00 afterwards; done=1.
6. With IMEM_LOADER_CHECKSUM_EN defined, load 2 words 00000001 and 00000002.
   - Trailer 00 00 00 03 gives done=1.
   - Trailer 00 00 00 04 gives err=1, done=0, cpu_hold=1.
